io_port_responder: RTL and testbench



---
 rtl/io_port_pkg.sv | 33 +++
 rtl/io_tx_fifo.sv | 96 +++++++++
 rtl/io_port_responder.sv | 110 +++++++++++
 tb/tb_io_port_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
// Shared constants for the memory-mapped I/O responder: register offsets,
// STATUS bit layout, default window base and a STATUS word packing helper.
package io_port_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_0000;

  // Word offsets taken from MemAddress[4:2]
  localparam logic [2:0] OFF_PORT_OUT  = 3'd0;
  localparam logic [2:0] OFF_PORT_IN   = 3'd1;
  localparam logic [2:0] OFF_IN_CHANGE = 3'd2;
  localparam logic [2:0] OFF_TX_DATA   = 3'd3;
  localparam logic [2:0] OFF_STATUS    = 3'd4;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 4;
  localparam int STATUS_COUNT_MSB = 8;
  localparam int STATUS_OVF_BIT   = 12;

  function automatic logic [31:0] status_word(input logic       empty,
                                              input logic       full,
                                              input logic [4:0] count,
                                              input logic       ovf);
    logic [31:0] w;
    w = '0;
    w[STATUS_EMPTY_BIT]                  = empty;
    w[STATUS_FULL_BIT]                   = full;
    w[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = count;
    w[STATUS_OVF_BIT]                    = ovf;
    return w;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Synchronous transmit FIFO with registered head/valid outputs, occupancy
// count and a one-cycle overflow pulse for a push that could not be accepted.
module io_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    rd_next;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign rd_next = rd_ptr_q + PW'(1);

  // A pop frees the slot the same push may use, so a full FIFO still accepts.
  assign do_pop     = pop_i & valid_q;
  assign do_push    = push_i & (~full | do_pop);
  assign overflow_o = push_i & full & ~do_pop;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_next;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Head seen after this edge: the next stored entry, or the pushed byte
    // when the FIFO holds nothing else.
    if (count_d == '0)
      head_d = '0;
    else if (do_pop)
      head_d = (count_q == CW'(1)) ? push_data_i : mem_q[rd_next];
    else if (empty)
      head_d = push_data_i;
    else
      head_d = head_q;
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  // NOTE: storage is not reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = head_q;
  assign valid_o = valid_q;
  assign empty_o = empty;
  assign full_o  = full;
  assign count_o = count_q;

endmodule

// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder: PortOut register, synchronized PortIn with
// sticky change flags, and a byte transmit FIFO with valid/ready drain.
module io_port_responder
  import io_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MemAddress,
  input  logic [31:0] MemWriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] MemReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]  offset;
  logic        wr_en;
  logic [31:0] port_out_q, port_out_d;
  logic [7:0]  sync_q [SYNC_STAGES];
  logic [7:0]  sync_prev_q;
  logic [7:0]  in_sync;
  logic [7:0]  in_change_q, in_change_d;
  logic [7:0]  chg_clr;
  logic        ovf_q, ovf_d, ovf_clr;
  logic        tx_push;
  logic        fifo_empty, fifo_full, fifo_ovf;
  logic [CW-1:0] fifo_count;
  logic        unused_addr_bits;

  assign Hit     = (MemAddress[31:5] == BASE_ADDR[31:5]);
  assign offset  = MemAddress[4:2];
  assign wr_en   = Hit & MemWrite;
  assign in_sync = sync_q[SYNC_STAGES-1];
  assign unused_addr_bits = ^MemAddress[1:0];

  assign tx_push = wr_en & (offset == OFF_TX_DATA);
  assign chg_clr = (wr_en && offset == OFF_IN_CHANGE) ? MemWriteData[7:0] : 8'h00;
  assign ovf_clr = wr_en & (offset == OFF_STATUS) & MemWriteData[STATUS_OVF_BIT];

  always_comb begin
    port_out_d = port_out_q;
    if (wr_en && offset == OFF_PORT_OUT) port_out_d = MemWriteData;
    // Sets are OR-ed after the clear so a same-cycle set always wins.
    in_change_d = (in_change_q & ~chg_clr) | (in_sync ^ sync_prev_q);
    ovf_d       = (ovf_q & ~ovf_clr) | fifo_ovf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port_out_q  <= '0;
      sync_prev_q <= '0;
      in_change_q <= '0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      port_out_q  <= port_out_d;
      sync_prev_q <= in_sync;
      in_change_q <= in_change_d;
      ovf_q       <= ovf_d;
      sync_q[0]   <= PortIn;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  io_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8),
    .CW    (CW)
  ) u_tx_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (tx_push),
    .push_data_i (MemWriteData[7:0]),
    .pop_i       (TxReady),
    .head_o      (TxData),
    .valid_o     (TxValid),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count),
    .overflow_o  (fifo_ovf)
  );

  always_comb begin
    MemReadData = '0;
    if (Hit && MemRead) begin
      case (offset)
        OFF_PORT_OUT:  MemReadData = port_out_q;
        OFF_PORT_IN:   MemReadData = {24'b0, in_sync};
        OFF_IN_CHANGE: MemReadData = {24'b0, in_change_q};
        OFF_STATUS:    MemReadData = status_word(fifo_empty, fifo_full,
                                                 5'(fifo_count), ovf_q);
        default:       MemReadData = '0;
      endcase
    end
  end

  assign PortOut = port_out_q;

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: register map, PortIn synchronizer and
// change flags, transmit FIFO push/pop/overflow and synchronous reset.
module tb_io_port_responder;

  localparam logic [31:0] A_OUT    = 32'hFFFF_0000;
  localparam logic [31:0] A_IN     = 32'hFFFF_0004;
  localparam logic [31:0] A_CHG    = 32'hFFFF_0008;
  localparam logic [31:0] A_TX     = 32'hFFFF_000C;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] MemAddress, MemWriteData, MemReadData, PortOut;
  logic        MemWrite, MemRead, Hit, TxValid, TxReady;
  logic [7:0]  PortIn, TxData;

  int n_total = 0;
  int n_bad   = 0;

  io_port_responder dut (
    .clk          (clk),
    .reset        (reset),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemReadData  (MemReadData),
    .Hit          (Hit),
    .PortIn       (PortIn),
    .PortOut      (PortOut),
    .TxData       (TxData),
    .TxValid      (TxValid),
    .TxReady      (TxReady)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    MemAddress   = addr;
    MemWriteData = data;
    MemWrite     = 1'b1;
    tick();
    MemWrite     = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    MemAddress = addr;
    MemRead    = 1'b1;
    #1;
    check(tag, MemReadData, exp);
    MemRead    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    exp_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_b = '{8'hBB, 8'hCC, 8'hDD, 8'h66};

    reset = 1'b1; MemAddress = '0; MemWriteData = '0; MemWrite = 1'b0;
    MemRead = 1'b0; PortIn = 8'h00; TxReady = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_portout", PortOut, 32'h0);
    check("rst_txvalid", {31'b0, TxValid}, 32'h0);
    check("rst_txdata", {24'b0, TxData}, 32'h0);
    check("rst_hit_outside", {31'b0, Hit}, 32'h0);
    read_check("rst_status", A_STATUS, 32'h0000_0001);
    read_check("rst_inchg", A_CHG, 32'h0);

    // PortOut write/read and out-of-window store
    bus_write(A_OUT, 32'hDEADBEEF);
    check("portout_write", PortOut, 32'hDEADBEEF);
    read_check("portout_read", A_OUT, 32'hDEADBEEF);
    check("hit_inside", {31'b0, Hit}, 32'h1);
    bus_write(32'h1001_0000, 32'h1234_5678);
    check("portout_outside", PortOut, 32'hDEADBEEF);
    check("hit_outside", {31'b0, Hit}, 32'h0);
    read_check("read_outside", 32'h1001_0000, 32'h0);
    MemAddress = A_OUT; #1;
    check("no_read_strobe", MemReadData, 32'h0);

    // Synchronizer latency and change detection
    PortIn = 8'hA5;
    tick();
    read_check("portin_lat1", A_IN, 32'h0);
    tick();
    read_check("portin_lat2", A_IN, 32'h0000_00A5);
    read_check("inchg_not_yet", A_CHG, 32'h0);
    tick();
    read_check("inchg_set", A_CHG, 32'h0000_00A5);
    bus_write(A_CHG, 32'h0000_0005);
    read_check("inchg_clr05", A_CHG, 32'h0000_00A0);
    PortIn = 8'h25;
    tick(); tick();
    bus_write(A_CHG, 32'h0000_0080);
    read_check("inchg_set_wins", A_CHG, 32'h0000_00A0);
    bus_write(A_CHG, 32'h0000_00A0);
    read_check("inchg_clr_all", A_CHG, 32'h0);
    read_check("portin_toggled", A_IN, 32'h0000_0025);

    // Fill FIFO, overflow, clear overflow, drain in order
    for (int i = 0; i < 4; i++) bus_write(A_TX, {24'b0, exp_a[i]});
    read_check("fifo_full_status", A_STATUS, 32'h0000_0042);
    check("fifo_head", {24'b0, TxData}, 32'h11);
    bus_write(A_TX, 32'h0000_0055);
    read_check("fifo_overflow", A_STATUS, 32'h0000_1042);
    bus_write(A_STATUS, 32'h0000_1000);
    read_check("ovf_clear", A_STATUS, 32'h0000_0042);
    TxReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_a_valid%0d", i), {31'b0, TxValid}, 32'h1);
      check($sformatf("drain_a_data%0d", i), {24'b0, TxData}, {24'b0, exp_a[i]});
      tick();
    end
    TxReady = 1'b0;
    check("drain_a_done", {31'b0, TxValid}, 32'h0);
    read_check("drain_a_status", A_STATUS, 32'h0000_0001);

    // Push and pop in the same cycle while full
    bus_write(A_TX, 32'hAA);
    bus_write(A_TX, 32'hBB);
    bus_write(A_TX, 32'hCC);
    bus_write(A_TX, 32'hDD);
    MemAddress = A_TX; MemWriteData = 32'h66; MemWrite = 1'b1; TxReady = 1'b1;
    tick();
    MemWrite = 1'b0; TxReady = 1'b0;
    read_check("full_pushpop_status", A_STATUS, 32'h0000_0042);
    TxReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_b_data%0d", i), {24'b0, TxData}, {24'b0, exp_b[i]});
      tick();
    end
    TxReady = 1'b0;
    check("drain_b_done", {31'b0, TxValid}, 32'h0);

    // Push into empty FIFO, then reset mid-transfer
    MemAddress = A_TX; MemWriteData = 32'h77; MemWrite = 1'b1;
    #1;
    check("push_empty_pre", {31'b0, TxValid}, 32'h0);
    tick();
    MemWrite = 1'b0;
    check("push_empty_valid", {31'b0, TxValid}, 32'h1);
    check("push_empty_data", {24'b0, TxData}, 32'h77);
    reset = 1'b1;
    tick();
    check("reset_txvalid", {31'b0, TxValid}, 32'h0);
    check("reset_txdata", {24'b0, TxData}, 32'h0);
    check("reset_portout", PortOut, 32'h0);
    reset = 1'b0;
    read_check("reset_status", A_STATUS, 32'h0000_0001);

    // Byte-offset bits ignored; unmapped and write-only offsets read 0
    bus_write(32'hFFFF_0003, 32'hCAFE_0001);
    check("byte_bits_ignored", PortOut, 32'hCAFE_0001);
    read_check("read_off14", 32'hFFFF_0014, 32'h0);
    read_check("read_off18", 32'hFFFF_0018, 32'h0);
    read_check("read_off1c", 32'hFFFF_001C, 32'h0);
    bus_write(32'hFFFF_0014, 32'hFFFF_FFFF);
    check("write_off14_ignored", PortOut, 32'hCAFE_0001);
    read_check("status_after_off14", A_STATUS, 32'h0000_0001);
    bus_write(A_TX, 32'h0000_0099);
    read_check("read_txdata_zero", A_TX, 32'h0);
    read_check("status_one_entry", A_STATUS, 32'h0000_0010);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
